mem_access_unit: RTL

- Memory-stage load/store engine. It consumes the decoder's memory controls (`data_en`, `data_dtl`, `RFdtl`) together with the EX-stage address and store data.
- It drives the SRAM-like data bus with request/address and data handshakes.
- It returns load results to writeback: lane-extracted, sign/zero-extended, and lwl/lwr-merged.
- It raises AdEL/AdES address-error flags for misaligned word/half accesses.

---
 rtl/mem_access_unit_pkg.sv | 48 ++++
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mau_lane_align.sv | 91 +++++++++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared definitions for the memory-stage load/store engine:
//   - MEM_DTL_* : bit indices of the one-hot store-kind vector (data_dtl)
//   - RF_DTL_*  : bit indices of the one-hot load-kind vector (RFdtl)
//   - SIZE_*    : data_size encodings on the SRAM-like bus
//   - mau_state_e : FSM state encodings (MAU_ST_*)
//   - mau_misaligned() : address-error predicate used when the optional
//     address check (macro MAU_ADDR_CHECK_EN) is compiled in
package mem_access_unit_pkg;

  localparam int MEM_DTL_WORD = 0;
  localparam int MEM_DTL_SWL  = 1;
  localparam int MEM_DTL_SWR  = 2;
  localparam int MEM_DTL_SB   = 3;
  localparam int MEM_DTL_SH   = 4;

  localparam int RF_DTL_WORD = 0;
  localparam int RF_DTL_LWL  = 1;
  localparam int RF_DTL_LWR  = 2;
  localparam int RF_DTL_LB   = 3;
  localparam int RF_DTL_LBU  = 4;
  localparam int RF_DTL_LH   = 5;
  localparam int RF_DTL_LHU  = 6;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    MAU_ST_IDLE   = 3'd0,
    MAU_ST_REQ    = 3'd1,
    MAU_ST_WAIT   = 3'd2,
    MAU_ST_DONE   = 3'd3,
    MAU_ST_CANCEL = 3'd4
  } mau_state_e;

  // Word and halfword accesses must be naturally aligned; lwl/lwr/swl/swr
  // and byte accesses never fault.
  function automatic logic mau_misaligned(input logic [4:0] st,
                                          input logic [6:0] ld,
                                          input logic [1:0] a);
    if (|st)
      return (st[MEM_DTL_WORD] && (a != 2'd0)) || (st[MEM_DTL_SH] && a[0]);
    return (ld[RF_DTL_WORD] && (a != 2'd0)) ||
           ((ld[RF_DTL_LH] || ld[RF_DTL_LHU]) && a[0]);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// SRAM-like data bus between the load/store engine (master) and memory
// (slave).
//   master drives: data_req, data_wr, data_size, data_addr, data_wstrb,
//                  data_wdata
//   slave drives : data_addr_ok, data_data_ok, data_rdata
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mau_lane_align.sv
// mau_lane_align
// Purely combinational byte-lane logic for the load/store engine.
//   st_dtl / ld_dtl : one-hot store / load kind (st_dtl all-zero = load)
//   addr, rt        : effective address and rt register value
//   rdata           : raw read data from the bus
//   bus_addr, size  : aligned bus address and access size
//   wstrb, wdata    : byte enables and lane-aligned store data (0 for loads)
//   ld_result       : extracted / extended / merged load value (0 for stores)
module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [4:0]        st_dtl,
  input  logic [6:0]        ld_dtl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rt,
  input  logic [31:0]       rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        size,
  output logic [3:0]        wstrb,
  output logic [31:0]       wdata,
  output logic [31:0]       ld_result
);
  logic [1:0]  a;
  logic [31:0] rd_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign a        = addr[1:0];
  assign rd_shift = rdata >> {a, 3'b000};
  assign ld_byte  = rd_shift[7:0];
  assign ld_half  = a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    size      = SIZE_WORD;
    bus_addr  = {addr[ADDR_W-1:2], 2'b00};
    wstrb     = 4'b0000;
    wdata     = 32'h0;
    ld_result = 32'h0;
    if (|st_dtl) begin
      if (st_dtl[MEM_DTL_SB]) begin
        size     = SIZE_BYTE;
        bus_addr = addr;
        wstrb    = 4'b0001 << a;
        wdata    = {4{rt[7:0]}};
      end else if (st_dtl[MEM_DTL_SH]) begin
        size     = SIZE_HALF;
        bus_addr = {addr[ADDR_W-1:1], 1'b0};
        wstrb    = a[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{rt[15:0]}};
      end else if (st_dtl[MEM_DTL_SWL]) begin
        // ~a == 3 - a for a 2-bit offset: high bytes of rt go to low lanes
        wstrb = 4'b1111 >> (~a);
        wdata = rt >> {~a, 3'b000};
      end else if (st_dtl[MEM_DTL_SWR]) begin
        wstrb = 4'b1111 << a;
        wdata = rt << {a, 3'b000};
      end else if (st_dtl[MEM_DTL_WORD]) begin
        wstrb = 4'b1111;
        wdata = rt;
      end
    end else begin
      if (ld_dtl[RF_DTL_LB] || ld_dtl[RF_DTL_LBU]) begin
        size      = SIZE_BYTE;
        bus_addr  = addr;
        ld_result = {{24{ld_dtl[RF_DTL_LB] & ld_byte[7]}}, ld_byte};
      end else if (ld_dtl[RF_DTL_LH] || ld_dtl[RF_DTL_LHU]) begin
        size      = SIZE_HALF;
        bus_addr  = {addr[ADDR_W-1:1], 1'b0};
        ld_result = {{16{ld_dtl[RF_DTL_LH] & ld_half[15]}}, ld_half};
      end else if (ld_dtl[RF_DTL_LWL]) begin
        case (a)
          2'd0:    ld_result = {rdata[7:0],  rt[23:0]};
          2'd1:    ld_result = {rdata[15:0], rt[15:0]};
          2'd2:    ld_result = {rdata[23:0], rt[7:0]};
          default: ld_result = rdata;
        endcase
      end else if (ld_dtl[RF_DTL_LWR]) begin
        case (a)
          2'd0:    ld_result = rdata;
          2'd1:    ld_result = {rt[31:24], rdata[31:8]};
          2'd2:    ld_result = {rt[31:16], rdata[31:16]};
          default: ld_result = {rt[31:8],  rdata[31:24]};
        endcase
      end else if (ld_dtl[RF_DTL_WORD] || (ld_dtl == 7'd0)) begin
        ld_result = rdata;
      end
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store engine. Accepts one memory op from EX at a time,
// runs it on the SRAM-like bus and returns a one-cycle completion pulse
// with the load result (or address-error flags) to writeback.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready : op handshake from EX (ready only in IDLE)
//   in_data_en, in_data_dtl, in_rf_dtl, in_addr, in_rt : op description
//   flush             : pipeline flush, cancels the op in flight
//   bus               : SRAM-like data bus (mem_access_unit_if.master)
//   wb_valid, wb_rdata, adel, ades, badvaddr : completion to writeback
// Optional feature: define MAU_ADDR_CHECK_EN to fault misaligned word/half
// accesses instead of silently aligning them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_data_en,
  input  logic [4:0]        in_data_dtl,
  input  logic [6:0]        in_rf_dtl,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_rt,
  input  logic              flush,
  mem_access_unit_if.master bus,
  output logic              wb_valid,
  output logic [31:0]       wb_rdata,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);
  mau_state_e        state_q, state_d;
  logic [4:0]        st_q, st_d;
  logic [6:0]        ld_q, ld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rt_q, rt_d;
  logic [31:0]       wb_rdata_q, wb_rdata_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;

  logic              addr_err;
  logic [ADDR_W-1:0] la_addr;
  logic [1:0]        la_size;
  logic [3:0]        la_wstrb;
  logic [31:0]       la_wdata;
  logic [31:0]       la_result;
  logic              req_active;

`ifdef MAU_ADDR_CHECK_EN
  assign addr_err = mau_misaligned(in_data_dtl, in_rf_dtl, in_addr[1:0]);
`else
  assign addr_err = 1'b0;
`endif

  // Lane logic works on the latched op so the bus stays stable in REQ.
  mau_lane_align #(.ADDR_W(ADDR_W)) u_lane_align (
    .st_dtl    (st_q),
    .ld_dtl    (ld_q),
    .addr      (addr_q),
    .rt        (rt_q),
    .rdata     (bus.data_rdata),
    .bus_addr  (la_addr),
    .size      (la_size),
    .wstrb     (la_wstrb),
    .wdata     (la_wdata),
    .ld_result (la_result)
  );

  assign req_active      = (state_q == MAU_ST_REQ);
  assign bus.data_req    = req_active;
  assign bus.data_wr     = req_active & (|st_q);
  assign bus.data_size   = req_active ? la_size : 2'd0;
  assign bus.data_addr   = req_active ? la_addr : '0;
  assign bus.data_wstrb  = req_active ? la_wstrb : 4'd0;
  assign bus.data_wdata  = req_active ? la_wdata : 32'd0;

  assign in_ready = (state_q == MAU_ST_IDLE);
  // A flush landing on the DONE cycle kills the writeback pulse.
  assign wb_valid = (state_q == MAU_ST_DONE) & ~flush;
  assign wb_rdata = wb_rdata_q;
  assign adel     = adel_q & wb_valid;
  assign ades     = ades_q & wb_valid;
  assign badvaddr = badvaddr_q;

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    ld_d       = ld_q;
    addr_d     = addr_q;
    rt_d       = rt_q;
    wb_rdata_d = wb_rdata_q;
    adel_d     = adel_q;
    ades_d     = ades_q;
    badvaddr_d = badvaddr_q;
    case (state_q)
      MAU_ST_IDLE: begin
        if (in_valid && in_data_en) begin
          st_d       = in_data_dtl;
          ld_d       = in_rf_dtl;
          addr_d     = in_addr;
          rt_d       = in_rt;
          wb_rdata_d = 32'h0;
          adel_d     = addr_err & ~(|in_data_dtl);
          ades_d     = addr_err & (|in_data_dtl);
          badvaddr_d = addr_err ? in_addr : '0;
          state_d    = addr_err ? MAU_ST_DONE : MAU_ST_REQ;
        end
      end
      MAU_ST_REQ: begin
        if (flush) begin
          // Accepted but unanswered requests must be drained in CANCEL; a
          // request answered in the same cycle is already complete.
          if (bus.data_addr_ok && !bus.data_data_ok) state_d = MAU_ST_CANCEL;
          else                                       state_d = MAU_ST_IDLE;
        end else if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            wb_rdata_d = la_result;
            state_d    = MAU_ST_DONE;
          end else begin
            state_d = MAU_ST_WAIT;
          end
        end
      end
      MAU_ST_WAIT: begin
        if (bus.data_data_ok) begin
          wb_rdata_d = la_result;
          state_d    = flush ? MAU_ST_IDLE : MAU_ST_DONE;
        end else if (flush) begin
          state_d = MAU_ST_CANCEL;
        end
      end
      MAU_ST_DONE:   state_d = MAU_ST_IDLE;
      MAU_ST_CANCEL: if (bus.data_data_ok) state_d = MAU_ST_IDLE;
      default:       state_d = MAU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MAU_ST_IDLE;
      st_q       <= '0;
      ld_q       <= '0;
      addr_q     <= '0;
      rt_q       <= '0;
      wb_rdata_q <= '0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      ld_q       <= ld_d;
      addr_q     <= addr_d;
      rt_q       <= rt_d;
      wb_rdata_q <= wb_rdata_d;
      adel_q     <= adel_d;
      ades_q     <= ades_d;
      badvaddr_q <= badvaddr_d;
    end
  end
endmodule
